custom_axi_ip_regs: RTL and testbench

AXI4-Lite slave register file that sits directly upstream of the custom_axi_ip processing core. It holds the input data word and issues the one-cycle start strobe (ipreg_data, enable_in) to the core. It captures the core's result on its write-enable (ipreg_data_out, wen_out) and exposes core status and a sticky done flag to software.

---
 rtl/custom_axi_ip_regs.sv | 193 +++++++++++++++++++
 tb/tb_custom_axi_ip_regs.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_axi_ip_regs.sv
// AXI4-Lite register file in front of the custom_axi_ip core: holds the core's input
// word, fires its one-cycle start strobe and captures the core's result and status.
module custom_axi_ip_regs #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [ADDR_WIDTH-1:0]     s_awaddr_i,
    input  logic                      s_awvalid_i,
    output logic                      s_awready_o,
    input  logic [DATA_WIDTH-1:0]     s_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb_i,
    input  logic                      s_wvalid_i,
    output logic                      s_wready_o,
    output logic [1:0]                s_bresp_o,
    output logic                      s_bvalid_o,
    input  logic                      s_bready_i,
    input  logic [ADDR_WIDTH-1:0]     s_araddr_i,
    input  logic                      s_arvalid_i,
    output logic                      s_arready_o,
    output logic [DATA_WIDTH-1:0]     s_rdata_o,
    output logic [1:0]                s_rresp_o,
    output logic                      s_rvalid_o,
    input  logic                      s_rready_i,
    output logic [DATA_WIDTH-1:0]     ipreg_data_o,
    output logic                      enable_o,
    input  logic [DATA_WIDTH-1:0]     hw_data_i,
    input  logic                      hw_wen_i,
    input  logic [1:0]                status_i
);

    localparam int         STRB_WIDTH   = DATA_WIDTH / 8;
    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_DATA_IN  = 2'd1;
    localparam logic [1:0] REG_DATA_OUT = 2'd2;
    localparam logic [1:0] REG_STATUS   = 2'd3;
    localparam logic [1:0] RESP_OKAY    = 2'b00;

    typedef enum logic {W_IDLE, W_RESP} wState_t;
    typedef enum logic {R_IDLE, R_DATA} rState_t;

    wState_t               r_wState;
    wState_t               w_wStateNext;
    rState_t               r_rState;
    rState_t               w_rStateNext;
    logic                  w_wrFire;
    logic                  w_bValid;
    logic                  w_rdFire;
    logic                  w_rValid;
    logic [1:0]            w_wrReg;
    logic [1:0]            w_rdReg;
    logic [DATA_WIDTH-1:0] w_rdMux;
    logic [DATA_WIDTH-1:0] r_dataIn;
    logic [DATA_WIDTH-1:0] r_dataOut;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_done;
    logic                  r_enable;
    logic                  w_unused;

    // Only word-aligned register selection is decoded; the remaining address bits are don't-care.
    assign w_wrReg  = s_awaddr_i[3:2];
    assign w_rdReg  = s_araddr_i[3:2];
    assign w_unused = ^{s_awaddr_i, s_araddr_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wState <= W_IDLE;
        end else begin
            r_wState <= w_wStateNext;
        end
    end

    // Address and data are only taken together, so a lone AW or W simply waits.
    always_comb begin
        w_wStateNext = r_wState;
        w_wrFire     = 1'b0;
        w_bValid     = 1'b0;
        case (r_wState)
            W_IDLE: begin
                if (s_awvalid_i && s_wvalid_i) begin
                    w_wrFire     = 1'b1;
                    w_wStateNext = W_RESP;
                end
            end
            W_RESP: begin
                w_bValid = 1'b1;
                if (s_bready_i) begin
                    w_wStateNext = W_IDLE;
                end
            end
            default: w_wStateNext = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rState <= R_IDLE;
        end else begin
            r_rState <= w_rStateNext;
        end
    end

    always_comb begin
        w_rStateNext = r_rState;
        w_rdFire     = 1'b0;
        w_rValid     = 1'b0;
        case (r_rState)
            R_IDLE: begin
                if (s_arvalid_i) begin
                    w_rdFire     = 1'b1;
                    w_rStateNext = R_DATA;
                end
            end
            R_DATA: begin
                w_rValid = 1'b1;
                if (s_rready_i) begin
                    w_rStateNext = R_IDLE;
                end
            end
            default: w_rStateNext = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dataIn <= '0;
        end else if (w_wrFire && (w_wrReg == REG_DATA_IN)) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_wstrb_i[i]) begin
                    r_dataIn[8*i +: 8] <= s_wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_enable <= 1'b0;
        end else begin
            r_enable <= w_wrFire && (w_wrReg == REG_CTRL) && s_wstrb_i[0] && s_wdata_i[0];
        end
    end

    // A core result arriving in the same cycle as a software clear keeps DONE set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dataOut <= '0;
            r_done    <= 1'b0;
        end else begin
            if (hw_wen_i) begin
                r_dataOut <= hw_data_i;
            end
            if (hw_wen_i) begin
                r_done <= 1'b1;
            end else if (w_wrFire && (w_wrReg == REG_STATUS) && s_wstrb_i[0] && s_wdata_i[2]) begin
                r_done <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdMux = '0;
        case (w_rdReg)
            REG_CTRL:     w_rdMux = '0;
            REG_DATA_IN:  w_rdMux = r_dataIn;
            REG_DATA_OUT: w_rdMux = r_dataOut;
            REG_STATUS:   w_rdMux = {{(DATA_WIDTH-3){1'b0}}, r_done, status_i};
            default:      w_rdMux = '0;
        endcase
    end

    // Read data is captured at the AR handshake and held until the master takes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= '0;
        end else if (w_rdFire) begin
            r_rdata <= w_rdMux;
        end
    end

    assign s_awready_o  = w_wrFire;
    assign s_wready_o   = w_wrFire;
    assign s_bvalid_o   = w_bValid;
    assign s_bresp_o    = RESP_OKAY;
    assign s_arready_o  = w_rdFire;
    assign s_rvalid_o   = w_rValid;
    assign s_rdata_o    = r_rdata;
    assign s_rresp_o    = RESP_OKAY;
    assign ipreg_data_o = r_dataIn;
    assign enable_o     = r_enable;

endmodule

// File: tb/tb_custom_axi_ip_regs.sv
// Scoreboard bench for custom_axi_ip_regs: directed scenarios plus randomized AXI-Lite
// traffic, checked against a register-level model of the address map.
module tb_custom_axi_ip_regs;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [3:0]  s_awaddr_i;
    logic        s_awvalid_i;
    logic        s_awready_o;
    logic [31:0] s_wdata_i;
    logic [3:0]  s_wstrb_i;
    logic        s_wvalid_i;
    logic        s_wready_o;
    logic [1:0]  s_bresp_o;
    logic        s_bvalid_o;
    logic        s_bready_i;
    logic [3:0]  s_araddr_i;
    logic        s_arvalid_i;
    logic        s_arready_o;
    logic [31:0] s_rdata_o;
    logic [1:0]  s_rresp_o;
    logic        s_rvalid_o;
    logic        s_rready_i;
    logic [31:0] ipreg_data_o;
    logic        enable_o;
    logic [31:0] hw_data_i;
    logic        hw_wen_i;
    logic [1:0]  status_i;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mDataIn    = '0;
    logic [31:0] mDataOut   = '0;
    logic        mDone      = 1'b0;
    logic        mEnableExp = 1'b0;
    logic [31:0] expRdata[$];
    logic [1:0]  expBresp[$];
    logic [31:0] lastRdata  = '0;

    always #5 clk_i = ~clk_i;

    custom_axi_ip_regs #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
        .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
        .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
        .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
        .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
        .ipreg_data_o(ipreg_data_o), .enable_o(enable_o),
        .hw_data_i(hw_data_i), .hw_wen_i(hw_wen_i), .status_i(status_i)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h time=%0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] readModel(input logic [1:0] reg_sel);
        case (reg_sel)
            2'd1:    return mDataIn;
            2'd2:    return mDataOut;
            2'd3:    return {29'd0, mDone, status_i};
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: inputs only change just after a rising edge, so what is seen at the
    // falling edge is exactly what the next rising edge will act on.
    initial begin
        logic nextEnable;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                mDataIn    = '0;
                mDataOut   = '0;
                mDone      = 1'b0;
                mEnableExp = 1'b0;
                expRdata.delete();
                expBresp.delete();
            end else begin
                checkOutput("ipreg_data", ipreg_data_o, mDataIn);
                if (mEnableExp || enable_o) checkOutput("enable_pulse", 32'(enable_o), 32'(mEnableExp));
                if (s_awready_o || s_wready_o) begin
                    checkOutput("aw_w_ready_together", 32'(s_awready_o), 32'(s_wready_o));
                    checkOutput("ready_needs_both_valid", 32'(s_awvalid_i && s_wvalid_i), 32'd1);
                end
                nextEnable = 1'b0;
                if (s_arvalid_i && s_arready_o) expRdata.push_back(readModel(s_araddr_i[3:2]));
                if (s_awvalid_i && s_awready_o && s_wvalid_i && s_wready_o) begin
                    expBresp.push_back(2'b00);
                    case (s_awaddr_i[3:2])
                        2'd0: nextEnable = s_wstrb_i[0] && s_wdata_i[0];
                        2'd1: for (int b = 0; b < 4; b++)
                                  if (s_wstrb_i[b]) mDataIn[8*b +: 8] = s_wdata_i[8*b +: 8];
                        2'd3: if (s_wstrb_i[0] && s_wdata_i[2]) mDone = 1'b0;
                        default: ;
                    endcase
                end
                if (hw_wen_i) begin
                    mDataOut = hw_data_i;
                    mDone    = 1'b1;
                end
                mEnableExp = nextEnable;
            end
        end
    end

    // Monitor: pops the expected response whenever the DUT completes a B or R handshake.
    initial begin
        logic        bHeld = 1'b0;
        logic        rHeld = 1'b0;
        logic [31:0] heldRdata = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                bHeld = 1'b0;
                rHeld = 1'b0;
            end else begin
                if (bHeld) checkOutput("bvalid_held", 32'(s_bvalid_o), 32'd1);
                if (rHeld) begin
                    checkOutput("rvalid_held", 32'(s_rvalid_o), 32'd1);
                    checkOutput("rdata_stable", s_rdata_o, heldRdata);
                end
                if (s_bvalid_o && s_bready_i) begin
                    checkOutput("b_expected", 32'(expBresp.size() != 0), 32'd1);
                    if (expBresp.size() != 0) checkOutput("bresp", 32'(s_bresp_o), 32'(expBresp.pop_front()));
                end
                if (s_rvalid_o && s_rready_i) begin
                    checkOutput("r_expected", 32'(expRdata.size() != 0), 32'd1);
                    if (expRdata.size() != 0) checkOutput("rdata", s_rdata_o, expRdata.pop_front());
                    checkOutput("rresp", 32'(s_rresp_o), 32'd0);
                end
                bHeld     = s_bvalid_o && !s_bready_i;
                rHeld     = s_rvalid_o && !s_rready_i;
                heldRdata = s_rdata_o;
            end
        end
    end

    task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int awLead, input int bDelay, input bit pulseWen, input logic [31:0] wenData);
        bit ok    = 1'b0;
        bit early = 1'b0;
        @(posedge clk_i); #1;
        s_awaddr_i  = addr;
        s_awvalid_i = 1'b1;
        s_wdata_i   = data;
        s_wstrb_i   = strb;
        repeat (awLead) begin
            @(negedge clk_i);
            if (s_awready_o || s_wready_o) early = 1'b1;
            @(posedge clk_i); #1;
        end
        if (awLead > 0) checkOutput("aw_alone_not_accepted", 32'(early), 32'd0);
        s_wvalid_i = 1'b1;
        if (pulseWen) begin
            hw_wen_i  = 1'b1;
            hw_data_i = wenData;
        end
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_i);
            ok = s_awready_o;
            @(posedge clk_i); #1;
            hw_wen_i = 1'b0;
        end
        s_awvalid_i = 1'b0;
        s_wvalid_i  = 1'b0;
        checkOutput("aw_w_handshake", 32'(ok), 32'd1);
        repeat (bDelay) begin
            @(posedge clk_i); #1;
        end
        s_bready_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_i);
            ok = s_bvalid_o;
            @(posedge clk_i); #1;
        end
        s_bready_i = 1'b0;
        checkOutput("b_handshake", 32'(ok), 32'd1);
    endtask

    task automatic axiRead(input logic [3:0] addr, input int rDelay, input bit pulseWen, input logic [31:0] wenData);
        bit ok = 1'b0;
        @(posedge clk_i); #1;
        s_araddr_i  = addr;
        s_arvalid_i = 1'b1;
        if (pulseWen) begin
            hw_wen_i  = 1'b1;
            hw_data_i = wenData;
        end
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_i);
            ok = s_arready_o;
            @(posedge clk_i); #1;
            hw_wen_i = 1'b0;
        end
        s_arvalid_i = 1'b0;
        checkOutput("ar_handshake", 32'(ok), 32'd1);
        repeat (rDelay) begin
            @(posedge clk_i); #1;
        end
        s_rready_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_i);
            ok = s_rvalid_o;
            if (ok) lastRdata = s_rdata_o;
            @(posedge clk_i); #1;
        end
        s_rready_i = 1'b0;
        checkOutput("r_handshake", 32'(ok), 32'd1);
    endtask

    // Stand-in for the core: returns its input word plus one after some latency.
    task automatic coreRespond(input int latency);
        logic [31:0] result;
        result = ipreg_data_o + 32'd1;
        repeat (latency) begin
            @(posedge clk_i); #1;
        end
        hw_data_i = result;
        hw_wen_i  = 1'b1;
        @(posedge clk_i); #1;
        hw_wen_i  = 1'b0;
    endtask

    task automatic applyStimulus(input int count);
        logic [3:0]  addr;
        logic [3:0]  raddr;
        for (int t = 0; t < count; t++) begin
            addr     = 4'($urandom);
            raddr    = 4'($urandom);
            status_i = 2'($urandom);
            case ($urandom_range(0, 5))
                0, 1: axiWrite(addr, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                               $urandom_range(0, 4) == 0, $urandom);
                2, 3: axiRead(raddr, $urandom_range(0, 3), $urandom_range(0, 4) == 0, $urandom);
                4: begin
                    axiWrite(4'h0, 32'd1, 4'hF, 0, $urandom_range(0, 2), 1'b0, 32'd0);
                    coreRespond($urandom_range(0, 4));
                end
                default: fork
                    axiWrite(addr, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 32'd0);
                    axiRead(raddr, $urandom_range(0, 3), 1'b0, 32'd0);
                join
            endcase
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_ni = 1'b0;
        s_awaddr_i = '0; s_awvalid_i = 1'b0; s_wdata_i = '0; s_wstrb_i = '0; s_wvalid_i = 1'b0;
        s_bready_i = 1'b0; s_araddr_i = '0; s_arvalid_i = 1'b0; s_rready_i = 1'b0;
        hw_data_i = '0; hw_wen_i = 1'b0; status_i = 2'd0;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset_awready", 32'(s_awready_o), 32'd0);
        checkOutput("reset_wready", 32'(s_wready_o), 32'd0);
        checkOutput("reset_bvalid", 32'(s_bvalid_o), 32'd0);
        checkOutput("reset_arready", 32'(s_arready_o), 32'd0);
        checkOutput("reset_rvalid", 32'(s_rvalid_o), 32'd0);
        checkOutput("reset_rdata", s_rdata_o, 32'd0);
        checkOutput("reset_resp", 32'({s_bresp_o, s_rresp_o}), 32'd0);
        checkOutput("reset_enable", 32'(enable_o), 32'd0);
        checkOutput("reset_ipreg", ipreg_data_o, 32'd0);
        rst_ni = 1'b1;

        status_i = 2'd2;
        axiRead(4'h0, 5, 1'b0, 32'd0);  checkOutput("t1_ctrl", lastRdata, 32'd0);
        axiRead(4'h4, 5, 1'b0, 32'd0);  checkOutput("t1_data_in", lastRdata, 32'd0);
        axiRead(4'h8, 5, 1'b0, 32'd0);  checkOutput("t1_data_out", lastRdata, 32'd0);
        axiRead(4'hC, 5, 1'b0, 32'd0);  checkOutput("t1_status", lastRdata, 32'd2);

        axiWrite(4'h4, 32'hDEADBEEF, 4'b0011, 0, 0, 1'b0, 32'd0);
        checkOutput("t2_ipreg", ipreg_data_o, 32'h0000BEEF);
        axiRead(4'h4, 0, 1'b0, 32'd0);  checkOutput("t2_data_in", lastRdata, 32'h0000BEEF);

        axiWrite(4'h0, 32'd1, 4'hF, 0, 0, 1'b0, 32'd0);
        coreRespond(2);
        axiRead(4'h8, 0, 1'b0, 32'd0);  checkOutput("t3_data_out", lastRdata, 32'h0000BEF0);
        axiRead(4'hC, 1, 1'b0, 32'd0);  checkOutput("t3_status_done", lastRdata, 32'h6);

        status_i = 2'd0;
        axiWrite(4'hC, 32'h4, 4'hF, 0, 0, 1'b0, 32'd0);
        axiRead(4'hC, 0, 1'b0, 32'd0);  checkOutput("t4_done_cleared", lastRdata, 32'h0);
        axiWrite(4'hC, 32'h4, 4'hF, 0, 0, 1'b1, 32'h12345678);
        axiRead(4'hC, 0, 1'b0, 32'd0);  checkOutput("t4_set_wins", lastRdata, 32'h4);
        axiRead(4'h8, 0, 1'b1, 32'hAAAA5555);
        checkOutput("t4_read_pre_update", lastRdata, 32'h12345678);
        axiRead(4'h8, 0, 1'b0, 32'd0);  checkOutput("t4_read_post_update", lastRdata, 32'hAAAA5555);

        axiWrite(4'h4, 32'hA5A55A5A, 4'hF, 3, 4, 1'b0, 32'd0);
        checkOutput("t5_ipreg", ipreg_data_o, 32'hA5A55A5A);

        applyStimulus(200);

        axiWrite(4'h4, 32'h12345678, 4'hF, 0, 0, 1'b0, 32'd0);
        @(posedge clk_i); #1;
        s_awaddr_i = 4'h0; s_wdata_i = 32'd1; s_wstrb_i = 4'hF;
        s_awvalid_i = 1'b1; s_wvalid_i = 1'b1;
        @(posedge clk_i); #1;
        s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
        checkOutput("t6_bvalid_before", 32'(s_bvalid_o), 32'd1);
        checkOutput("t6_enable_before", 32'(enable_o), 32'd1);
        #1 rst_ni = 1'b0;
        #1;
        checkOutput("t6_bvalid_dropped", 32'(s_bvalid_o), 32'd0);
        checkOutput("t6_enable_dropped", 32'(enable_o), 32'd0);
        checkOutput("t6_ipreg_cleared", ipreg_data_o, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        axiRead(4'h4, 0, 1'b0, 32'd0);  checkOutput("t6_data_in_after", lastRdata, 32'd0);

        repeat (5) @(posedge clk_i);
        #1;
        checkOutput("b_queue_drained", 32'(expBresp.size()), 32'd0);
        checkOutput("r_queue_drained", 32'(expRdata.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
